id_ex_alu_issue: RTL and testbench
==================================

// Module: id_ex_alu_issue
// PURPOSE
//  ID/EX pipeline stage feeding the 64-bit ALU. Captures one decoded instruction per transfer and
//  resolves operand A/B with EX/MEM and MEM/WB forwarding and the ALUSrc immediate mux. Translates
//  ALUOp + opcode into the ALU's 4-bit op code and presents registered alu_a/alu_b/alu_op to EX.
//  Valid/ready handshake on both sides; supports flush for branch mispredict; counts stall cycles.
// PARAMETERS
//  WIDTH      64  datapath width of operands, immediate and forwarded results
//  REGW        5  register-number width (register 31 = XZR)
//  CNTW       32  stall-counter width
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      asynchronous, active-low reset
//  in_valid       in   1      decode stage presents an instruction
//  in_ready       out  1      stage can accept this cycle
//  flush          in   1      kill held and incoming instruction
//  alu_op_ctrl    in   2      00 load/store, 01 CBZ, 10 R-type, 11 I-type
//  opcode         in   11     instruction opcode field
//  alu_src        in   1      1: operand B = imm
//  rn, rm, rd     in   REGW   source/destination register numbers
//  rn_val, rm_val in   WIDTH  register-file read data
//  imm            in   WIDTH  sign/zero-extended immediate
//  exm_wr, exm_rd, exm_res     in 1/REGW/WIDTH  EX/MEM writeback info
//  mwb_wr, mwb_rd, mwb_res     in 1/REGW/WIDTH  MEM/WB writeback info
//  out_valid      out  1      alu_* hold a valid instruction
//  out_ready      in   1      EX consumes this cycle
//  alu_a, alu_b   out  WIDTH  ALU operands
//  alu_op         out  4      ALU op code
//  out_rd         out  REGW   destination register carried to EX
//  illegal_op     out  1      opcode not decodable (registered with instruction)
//  stall_cnt      out  CNTW   cycles with out_valid && !out_ready
// BEHAVIOUR
//  - Reset: out_valid=0, alu_a=alu_b=0, alu_op=4'b0000, out_rd=0, illegal_op=0, stall_cnt=0.
//  - in_ready = !out_valid || out_ready (combinational). Capture when in_valid && in_ready && !flush.
//  - Latency 1 cycle input->output; full throughput with out_ready held high.
//  - Hold: out_valid && !out_ready -> all alu_* outputs stable, bit for bit.
//  - Consume without new capture -> out_valid=0 next cycle; data regs keep last value.
//  - flush has priority: next cycle out_valid=0 regardless of in_valid/out_ready; no capture.
//  - Forwarding per source (rn->A, rm->B): exm_wr && exm_rd==src && src!=31 -> exm_res; else
//    mwb_wr && mwb_rd==src && src!=31 -> mwb_res; else rf value. EX/MEM wins when both match.
//  - Operand B = imm when alu_src=1 (forwarding of rm ignored); else forwarded rm value.
//  - alu_op decode: ctrl 00 -> 0010 (ADD). ctrl 01 -> 0111 (pass B).
//    ctrl 10: 10001011000 ADD->0010, 11001011000 SUB->0110, 10001010000 AND->0000,
//    10101010000 ORR->0001. ctrl 11 (opcode[10:1]): 1001000100 ADDI->0010,
//    1101000100 SUBI->0110, 1001001000 ANDI->0000, 1011001000 ORRI->0001.
//    Any other opcode: alu_op=1111 (ALU default, passes A), illegal_op=1.
//  - stall_cnt increments each cycle out_valid && !out_ready; saturates at all-ones; no wrap.
//  - Mid-operation reset: outputs return to reset values immediately (async), instruction lost.
// STRUCTURE
//  - Shared package: ALU op-code constants (AND/OR/ADD/SUB/PASSB/NOR/DFLT), ALUOp class codes,
//    R- and I-format opcode constants, XZR index. Same constants used by the ALU bench.
//  - Sub-module alu_ctrl_decode: pure combinational (alu_op_ctrl, opcode) -> (alu_op, illegal_op).
//  - Top: forwarding muxes, ALUSrc mux, output register with handshake, stall counter.
// TESTING
//  1 Reset mid-stream: rst_n=0 with out_valid=1 -> out_valid=0, alu_op=0000, stall_cnt=0 at once.
//  2 R-type SUB, rn_val=9, rm_val=4, no hazards, out_ready=1 -> next cycle alu_a=9, alu_b=4,
//    alu_op=0110, out_valid=1; back-to-back ADD next cycle -> alu_op=0010 one cycle later.
//  3 Double hazard: rn=rd=3, exm_wr=1 exm_rd=3 exm_res=0x11, mwb_wr=1 mwb_rd=3 mwb_res=0x22
//    -> alu_a=0x11; same with rn=31 -> alu_a=rn_val (no forward from XZR).
//  4 ADDI alu_src=1 imm=0x100, rm forwarded 0x55 -> alu_b=0x100, alu_op=0010.
//  5 out_ready=0 for 5 cycles with valid held -> in_ready=0, outputs stable, stall_cnt=5;
//    flush during stall -> out_valid=0 next cycle, pending in_valid instruction dropped.
//  6 opcode 11111111111 with ctrl=10 -> alu_op=1111, illegal_op=1, out_valid=1.

Source files
------------

// File: rtl/id_ex_alu_issue_pkg.sv
// Shared constants for the ID/EX issue stage and the ALU: op codes, ALUOp classes,
// R/I-format opcodes and the zero-register index.
package id_ex_alu_issue_pkg;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;
   localparam logic [3:0] ALU_NOR   = 4'b1100;
   localparam logic [3:0] ALU_DFLT  = 4'b1111;

   typedef enum logic [1:0] {
      AOP_LDST  = 2'b00,
      AOP_CBZ   = 2'b01,
      AOP_RTYPE = 2'b10,
      AOP_ITYPE = 2'b11
   } alu_class_e;

   localparam logic [10:0] OPC_ADD = 11'b10001011000;
   localparam logic [10:0] OPC_SUB = 11'b11001011000;
   localparam logic [10:0] OPC_AND = 11'b10001010000;
   localparam logic [10:0] OPC_ORR = 11'b10101010000;

   // I-format opcodes are 10 bits wide; bit 0 of the 11-bit field belongs to the immediate.
   localparam logic [9:0] OPCI_ADDI = 10'b1001000100;
   localparam logic [9:0] OPCI_SUBI = 10'b1101000100;
   localparam logic [9:0] OPCI_ANDI = 10'b1001001000;
   localparam logic [9:0] OPCI_ORRI = 10'b1011001000;

   localparam int XZR_IDX = 31;

endpackage

// File: rtl/id_ex_alu_issue_alu_ctrl_decode.sv
// ALU control decode: maps the ALUOp class and opcode field onto the ALU's 4-bit op code.
// Undecodable opcodes select the ALU default (pass A) and raise illegal_op.
module alu_ctrl_decode
   import id_ex_alu_issue_pkg::*;
(
   input  logic [1:0]  alu_op_ctrl,
   input  logic [10:0] opcode,
   output logic [3:0]  alu_op,
   output logic        illegal_op
);

   always_comb begin
      // NOTE: every output gets a default first, so no path through the cases infers a latch.
      alu_op     = ALU_DFLT;
      illegal_op = 1'b0;
      case (alu_class_e'(alu_op_ctrl))
         AOP_LDST: alu_op = ALU_ADD;
         AOP_CBZ:  alu_op = ALU_PASSB;
         AOP_RTYPE: begin
            case (opcode)
               OPC_ADD: alu_op = ALU_ADD;
               OPC_SUB: alu_op = ALU_SUB;
               OPC_AND: alu_op = ALU_AND;
               OPC_ORR: alu_op = ALU_OR;
               default: illegal_op = 1'b1;
            endcase
         end
         AOP_ITYPE: begin
            case (opcode[10:1])
               OPCI_ADDI: alu_op = ALU_ADD;
               OPCI_SUBI: alu_op = ALU_SUB;
               OPCI_ANDI: alu_op = ALU_AND;
               OPCI_ORRI: alu_op = ALU_OR;
               default:   illegal_op = 1'b1;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX issue stage: operand forwarding, ALUSrc mux and ALU control decode into a
// single valid/ready output register, with flush and a saturating stall counter.
module id_ex_alu_issue
   import id_ex_alu_issue_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int REGW  = 5,
   parameter int CNTW  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   input  logic [1:0]       alu_op_ctrl,
   input  logic [10:0]      opcode,
   input  logic             alu_src,
   input  logic [REGW-1:0]  rn,
   input  logic [REGW-1:0]  rm,
   input  logic [REGW-1:0]  rd,
   input  logic [WIDTH-1:0] rn_val,
   input  logic [WIDTH-1:0] rm_val,
   input  logic [WIDTH-1:0] imm,
   input  logic             exm_wr,
   input  logic [REGW-1:0]  exm_rd,
   input  logic [WIDTH-1:0] exm_res,
   input  logic             mwb_wr,
   input  logic [REGW-1:0]  mwb_rd,
   input  logic [WIDTH-1:0] mwb_res,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_op,
   output logic [REGW-1:0]  out_rd,
   output logic             illegal_op,
   output logic [CNTW-1:0]  stall_cnt
);

   localparam logic [REGW-1:0] XZR = REGW'(XZR_IDX);

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [3:0]       op;
      logic [REGW-1:0]  rd;
      logic             illegal;
   } issue_t;

   logic            valid_q, valid_d;
   issue_t          issue_q, issue_d;
   logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

   logic [3:0]       dec_op;
   logic             dec_illegal;
   logic [WIDTH-1:0] fwd_a, fwd_b;
   logic             capture;

   alu_ctrl_decode u_alu_ctrl_decode (
      .alu_op_ctrl (alu_op_ctrl),
      .opcode      (opcode),
      .alu_op      (dec_op),
      .illegal_op  (dec_illegal)
   );

   // EX/MEM is the younger producer, so it wins over MEM/WB; XZR never forwards.
   function automatic logic [WIDTH-1:0] forward(input logic [REGW-1:0]  src,
                                                input logic [WIDTH-1:0] rf_val);
      if (exm_wr && exm_rd == src && src != XZR)
         return exm_res;
      else if (mwb_wr && mwb_rd == src && src != XZR)
         return mwb_res;
      else
         return rf_val;
   endfunction

   always_comb begin
      fwd_a = forward(rn, rn_val);
      fwd_b = alu_src ? imm : forward(rm, rm_val);
   end

   assign in_ready = !valid_q || out_ready;
   assign capture  = in_valid && in_ready && !flush;

   always_comb begin
      valid_d     = valid_q;
      issue_d     = issue_q;
      stall_cnt_d = stall_cnt_q;

      if (flush)
         valid_d = 1'b0;
      else if (capture)
         valid_d = 1'b1;
      else if (out_ready)
         valid_d = 1'b0;

      if (capture) begin
         issue_d.a       = fwd_a;
         issue_d.b       = fwd_b;
         issue_d.op      = dec_op;
         issue_d.rd      = rd;
         issue_d.illegal = dec_illegal;
      end

      if (valid_q && !out_ready && !(&stall_cnt_q))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         issue_q     <= '0;
         stall_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         valid_q     <= valid_d;
         issue_q     <= issue_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_valid  = valid_q;
   assign alu_a      = issue_q.a;
   assign alu_b      = issue_q.b;
   assign alu_op     = issue_q.op;
   assign out_rd     = issue_q.rd;
   assign illegal_op = issue_q.illegal;
   assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed bench for id_ex_alu_issue: decode, forwarding, ALUSrc, handshake, flush,
// stall counting/saturation and asynchronous reset, against hand-computed values.
module tb_id_ex_alu_issue;
   import id_ex_alu_issue_pkg::*;

   localparam int WIDTH = 64;
   localparam int REGW  = 5;
   localparam int CNTW  = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid, in_ready, flush;
   logic [1:0]       alu_op_ctrl;
   logic [10:0]      opcode;
   logic             alu_src;
   logic [REGW-1:0]  rn, rm, rd;
   logic [WIDTH-1:0] rn_val, rm_val, imm;
   logic             exm_wr, mwb_wr;
   logic [REGW-1:0]  exm_rd, mwb_rd;
   logic [WIDTH-1:0] exm_res, mwb_res;
   logic             out_valid, out_ready;
   logic [WIDTH-1:0] alu_a, alu_b;
   logic [3:0]       alu_op;
   logic [REGW-1:0]  out_rd;
   logic             illegal_op;
   logic [CNTW-1:0]  stall_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   id_ex_alu_issue #(.WIDTH(WIDTH), .REGW(REGW), .CNTW(CNTW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .alu_op_ctrl(alu_op_ctrl), .opcode(opcode), .alu_src(alu_src),
      .rn(rn), .rm(rm), .rd(rd), .rn_val(rn_val), .rm_val(rm_val), .imm(imm),
      .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_res(exm_res),
      .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_res(mwb_res),
      .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
      .alu_op(alu_op), .out_rd(out_rd), .illegal_op(illegal_op), .stall_cnt(stall_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [1:0] c, input logic [10:0] o, input logic src,
                            input logic [REGW-1:0] n, input logic [REGW-1:0] m,
                            input logic [REGW-1:0] d, input logic [WIDTH-1:0] nv,
                            input logic [WIDTH-1:0] mv, input logic [WIDTH-1:0] im);
      alu_op_ctrl = c; opcode = o; alu_src = src;
      rn = n; rm = m; rd = d; rn_val = nv; rm_val = mv; imm = im;
   endtask

   typedef struct {
      logic [1:0]  c;
      logic [10:0] o;
      logic [3:0]  op;
      logic        ill;
   } dec_vec_t;

   dec_vec_t vecs [10];

   initial begin
      vecs = '{
         '{2'b00, 11'b11111111111, 4'b0010, 1'b0},
         '{2'b01, 11'b00000000000, 4'b0111, 1'b0},
         '{2'b10, OPC_AND,         4'b0000, 1'b0},
         '{2'b10, OPC_ORR,         4'b0001, 1'b0},
         '{2'b11, {OPCI_SUBI, 1'b1}, 4'b0110, 1'b0},
         '{2'b11, {OPCI_ANDI, 1'b0}, 4'b0000, 1'b0},
         '{2'b11, {OPCI_ORRI, 1'b1}, 4'b0001, 1'b0},
         '{2'b10, 11'b11111111111, 4'b1111, 1'b1},
         '{2'b11, 11'b11111111111, 4'b1111, 1'b1},
         '{2'b10, 11'b10001011001, 4'b1111, 1'b1}
      };

      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      exm_wr = 1'b0; exm_rd = '0; exm_res = '0;
      mwb_wr = 1'b0; mwb_rd = '0; mwb_res = '0;
      set_instr(2'b00, '0, 1'b0, '0, '0, '0, '0, '0, '0);
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_a", alu_a, 0);
      check("rst_b", alu_b, 0);
      check("rst_op", alu_op, 0);
      check("rst_rd", out_rd, 0);
      check("rst_ill", illegal_op, 0);
      check("rst_stall", stall_cnt, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check("in_ready_idle", in_ready, 1);

      // R-type SUB then back-to-back ADD
      set_instr(2'b10, OPC_SUB, 1'b0, 5'd1, 5'd2, 5'd5, 64'd9, 64'd4, 64'd0);
      in_valid = 1'b1;
      step();
      check("sub_valid", out_valid, 1);
      check("sub_a", alu_a, 9);
      check("sub_b", alu_b, 4);
      check("sub_op", alu_op, 4'b0110);
      check("sub_rd", out_rd, 5);
      check("sub_ill", illegal_op, 0);
      set_instr(2'b10, OPC_ADD, 1'b0, 5'd1, 5'd2, 5'd6, 64'd7, 64'd8, 64'd0);
      step();
      check("add_valid", out_valid, 1);
      check("add_op", alu_op, 4'b0010);
      check("add_a", alu_a, 7);
      check("add_b", alu_b, 8);
      check("add_rd", out_rd, 6);

      // Decode table, one instruction per cycle
      foreach (vecs[i]) begin
         set_instr(vecs[i].c, vecs[i].o, 1'b0, 5'd1, 5'd2, 5'd3, 64'(i), 64'd0, 64'd0);
         step();
         check($sformatf("dec%0d_valid", i), out_valid, 1);
         check($sformatf("dec%0d_op", i), alu_op, vecs[i].op);
         check($sformatf("dec%0d_ill", i), illegal_op, vecs[i].ill);
         check($sformatf("dec%0d_a", i), alu_a, 64'(i));
      end

      // Forwarding: EX/MEM over MEM/WB, MEM/WB alone, none from XZR
      set_instr(2'b10, OPC_ADD, 1'b0, 5'd3, 5'd2, 5'd3, 64'hAA, 64'hBB, 64'd0);
      exm_wr = 1'b1; exm_rd = 5'd3; exm_res = 64'h11;
      mwb_wr = 1'b1; mwb_rd = 5'd3; mwb_res = 64'h22;
      step();
      check("fwd_both_a", alu_a, 64'h11);
      check("fwd_both_b", alu_b, 64'hBB);
      exm_wr = 1'b0;
      step();
      check("fwd_mwb_a", alu_a, 64'h22);
      exm_wr = 1'b1; exm_rd = 5'd31; mwb_rd = 5'd31; rn = 5'd31;
      step();
      check("fwd_xzr_a", alu_a, 64'hAA);
      exm_rd = 5'd7; mwb_rd = 5'd4; rm = 5'd4;
      step();
      check("fwd_mwb_b", alu_b, 64'h22);
      check("fwd_none_a", alu_a, 64'hAA);

      // ADDI: immediate overrides a forwarded rm
      set_instr(2'b11, {OPCI_ADDI, 1'b0}, 1'b1, 5'd1, 5'd6, 5'd8, 64'd3, 64'd9, 64'h100);
      exm_wr = 1'b1; exm_rd = 5'd6; exm_res = 64'h55; mwb_wr = 1'b0;
      step();
      check("addi_b", alu_b, 64'h100);
      check("addi_op", alu_op, 4'b0010);
      check("addi_a", alu_a, 3);
      alu_src = 1'b0;
      step();
      check("rm_fwd_b", alu_b, 64'h55);

      // Consume without capture: valid drops, data holds
      in_valid = 1'b0;
      step();
      check("drain_valid", out_valid, 0);
      check("drain_a", alu_a, 3);
      check("drain_b", alu_b, 64'h55);
      check("drain_stall", stall_cnt, 0);

      // Stall for 5 cycles, then flush while a new instruction is pending
      exm_wr = 1'b0;
      set_instr(2'b10, OPC_SUB, 1'b0, 5'd1, 5'd2, 5'd9, 64'h1234, 64'h10, 64'd0);
      in_valid = 1'b1;
      step();
      check("stl_cap_a", alu_a, 64'h1234);
      out_ready = 1'b0;
      set_instr(2'b10, OPC_ADD, 1'b0, 5'd1, 5'd2, 5'd10, 64'hDEAD, 64'd1, 64'd0);
      #1;
      check("stl_in_ready", in_ready, 0);
      for (int k = 1; k <= 5; k++) begin
         step();
         check($sformatf("stl%0d_valid", k), out_valid, 1);
         check($sformatf("stl%0d_in_ready", k), in_ready, 0);
         check($sformatf("stl%0d_a", k), alu_a, 64'h1234);
         check($sformatf("stl%0d_b", k), alu_b, 64'h10);
         check($sformatf("stl%0d_op", k), alu_op, 4'b0110);
         check($sformatf("stl%0d_rd", k), out_rd, 9);
         check($sformatf("stl%0d_cnt", k), stall_cnt, k);
      end
      flush = 1'b1;
      step();
      check("flush_valid", out_valid, 0);
      check("flush_a", alu_a, 64'h1234);
      check("flush_cnt", stall_cnt, 6);
      flush = 1'b0; in_valid = 1'b0;
      step();
      check("post_flush_valid", out_valid, 0);
      check("post_flush_cnt", stall_cnt, 6);

      // Stall counter saturation
      in_valid = 1'b1;
      step();
      check("sat_cap_valid", out_valid, 1);
      check("sat_cap_a", alu_a, 64'hDEAD);
      check("sat_cap_cnt", stall_cnt, 6);
      in_valid = 1'b0;
      step();
      check("sat_cnt7", stall_cnt, 7);
      step();
      check("sat_hold1", stall_cnt, 7);
      step();
      check("sat_hold2", stall_cnt, 7);

      // Asynchronous reset mid-stream
      #2 rst_n = 1'b0;
      #1;
      check("mrst_valid", out_valid, 0);
      check("mrst_op", alu_op, 0);
      check("mrst_a", alu_a, 0);
      check("mrst_rd", out_rd, 0);
      check("mrst_stall", stall_cnt, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1; in_valid = 1'b1;
      set_instr(2'b10, OPC_SUB, 1'b0, 5'd1, 5'd2, 5'd5, 64'd9, 64'd4, 64'd0);
      step();
      check("recover_valid", out_valid, 1);
      check("recover_op", alu_op, 4'b0110);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
